// File: rtl/fib_mon_pkg.sv
// Package for the Fibonacci store monitor.
// Holds the default parameter values, the captured-entry record layout and the
// helper that sizes the occupancy counter.
// Optional feature macro used by the top level: FIB_CHECK_EN.
package fib_mon_pkg;

  localparam int          DEF_DEPTH  = 8;
  localparam int unsigned DEF_WIN_LO = 2;
  localparam int unsigned DEF_WIN_HI = 511;
  localparam int          DEF_OUT_W  = 16;

  // One captured store: the low address bits and the low data bits.
  typedef struct packed {
    logic [8:0]           addr;
    logic [DEF_OUT_W-1:0] data;
  } fib_entry_t;

  // The occupancy counter must be able to represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fib_mon_fifo.sv
// First-word-fall-through FIFO used by the store monitor.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush_i      - synchronous empty; overrides push_i/pop_i
//   push_i       - write wdata_i at the tail (caller guarantees not full or popping)
//   pop_i        - drop the head entry (caller guarantees not empty)
//   wdata_i      - entry to write
//   rdata_o      - head entry, zero while empty
//   count_o      - current occupancy, 0..DEPTH
module fib_mon_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 25
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (pop_i)  rd_d = rd_q + PW'(1);
      // Pointers wrap naturally; the separate count disambiguates full/empty.
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/fib_store_monitor.sv
// Fibonacci store monitor: snoops the core's data-memory store bus, captures
// stores whose word address lies in [WIN_LO, WIN_HI] into a FWFT FIFO, and
// drains them on a valid/ready stream.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   st_en, st_addr, st_data    - snooped store strobe / word address / data
//   clear                      - synchronous flush of FIFO and sticky flags
//   out_valid, out_ready       - result stream handshake
//   out_data, out_addr         - low bits of the head entry's data / address
//   count                      - FIFO occupancy
//   overflow                   - sticky: an in-window store was dropped when full
//   fib_err                    - sticky: captured sequence broke the Fibonacci rule
// Optional feature: define FIB_CHECK_EN to build the Fibonacci checker;
// without it fib_err is tied low.
module fib_store_monitor
  import fib_mon_pkg::*;
#(
  parameter int          DEPTH  = DEF_DEPTH,
  parameter int unsigned WIN_LO = DEF_WIN_LO,
  parameter int unsigned WIN_HI = DEF_WIN_HI,
  parameter int          OUT_W  = DEF_OUT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      st_en,
  input  logic [31:0]               st_addr,
  input  logic [31:0]               st_data,
  input  logic                      clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [8:0]                out_addr,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      fib_err
);

  localparam int CW = cnt_w(DEPTH);

  typedef struct packed {
    logic [8:0]       addr;
    logic [OUT_W-1:0] data;
  } entry_t;

  logic   hit, full, pop, push;
  logic   overflow_q;
  entry_t wr_entry, head;

  assign hit  = st_en && (st_addr >= WIN_LO) && (st_addr <= WIN_HI);
  assign full = (count == CW'(DEPTH));
  assign pop  = out_valid && out_ready;
  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign push = hit && (!full || pop) && !clear;

  assign wr_entry.addr = st_addr[8:0];
  assign wr_entry.data = st_data[OUT_W-1:0];

  fib_mon_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (clear),
    .push_i  (push),
    .pop_i   (pop && !clear),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (count)
  );

  assign out_valid = (count != '0);
  assign out_data  = head.data;
  assign out_addr  = head.addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     overflow_q <= 1'b0;
    else if (clear)                 overflow_q <= 1'b0;
    else if (hit && full && !pop)   overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

`ifdef FIB_CHECK_EN
  logic [31:0] last1_q, last2_q;
  logic [1:0]  seen_q;
  logic        fib_err_q;

  // Only accepted pushes advance the checker; dropped stores are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last1_q   <= '0;
      last2_q   <= '0;
      seen_q    <= '0;
      fib_err_q <= 1'b0;
    end else if (clear) begin
      last1_q   <= '0;
      last2_q   <= '0;
      seen_q    <= '0;
      fib_err_q <= 1'b0;
    end else if (push) begin
      if (seen_q == 2'd2 && st_data != last1_q + last2_q) fib_err_q <= 1'b1;
      last2_q <= last1_q;
      last1_q <= st_data;
      if (seen_q != 2'd2) seen_q <= seen_q + 2'd1;
    end
  end

  assign fib_err = fib_err_q;
`else
  logic unused_data_hi;
  assign unused_data_hi = ^st_data[31:OUT_W];
  assign fib_err        = 1'b0;
`endif

endmodule

// File: tb/tb_fib_store_monitor.sv
module tb_fib_store_monitor;
  import fib_mon_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = cnt_w(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              st_en;
  logic [31:0]       st_addr;
  logic [31:0]       st_data;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [8:0]        out_addr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              fib_err;

  fib_store_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_en     (st_en),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .count     (count),
    .overflow  (overflow),
    .fib_err   (fib_err)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // Reference model state
  fib_entry_t  sbq[$];
  logic        m_ovf;
  logic        m_err;
  logic [31:0] m_l1, m_l2;
  int          m_seen;

  typedef struct {
    logic        en;
    logic [31:0] a;
    logic [31:0] d;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [31:0] ea;
    logic [31:0] ec;
  } vec_t;

  vec_t tab[10];

  function automatic logic fib_on();
`ifdef FIB_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    m_ovf  = 1'b0;
    m_err  = 1'b0;
    m_l1   = '0;
    m_l2   = '0;
    m_seen = 0;
  endtask

  // Drive one cycle of stimulus, compare against the model just before the
  // edge, then advance the model by that edge.
  task automatic cyc_x(input logic en, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic clr, input logic use_exp,
                       input logic ev, input logic [31:0] ed, input logic [31:0] ea,
                       input logic [31:0] ec);
    logic       hit, pop, full;
    fib_entry_t e;
    st_en     = en;
    st_addr   = a;
    st_data   = d;
    out_ready = rdy;
    clear     = clr;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
    chk("count",     32'(count),     32'(sbq.size()));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("fib_err",   32'(fib_err),   32'(fib_on() & m_err));
    if (sbq.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(sbq[0].data));
      chk("out_addr", 32'(out_addr), 32'(sbq[0].addr));
    end
    if (use_exp) begin
      chk("tab_valid", 32'(out_valid), 32'(ev));
      chk("tab_count", 32'(count), ec);
      if (ev) begin
        chk("tab_data", 32'(out_data), ed);
        chk("tab_addr", 32'(out_addr), ea);
      end
    end
    hit  = en && (a >= 32'd2) && (a <= 32'd511);
    pop  = (sbq.size() != 0) && rdy;
    full = (sbq.size() == DEPTH);
    if (clr) begin
      model_reset();
    end else begin
      if (pop) void'(sbq.pop_front());
      if (hit && (!full || pop)) begin
        e.addr = a[8:0];
        e.data = d[15:0];
        sbq.push_back(e);
        if (m_seen == 2 && d != m_l1 + m_l2) m_err = 1'b1;
        m_l2 = m_l1;
        m_l1 = d;
        if (m_seen < 2) m_seen++;
      end else if (hit) begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic en, input logic [31:0] a, input logic [31:0] d,
                     input logic rdy, input logic clr);
    cyc_x(en, a, d, rdy, clr, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    tab[0] = '{1'b1, 32'd2,   32'd0,  1'b1, 1'b0, 32'd0, 32'd0, 32'd0};
    tab[1] = '{1'b1, 32'd3,   32'd1,  1'b1, 1'b1, 32'd0, 32'd2, 32'd1};
    tab[2] = '{1'b1, 32'd4,   32'd1,  1'b1, 1'b1, 32'd1, 32'd3, 32'd1};
    tab[3] = '{1'b1, 32'd5,   32'd2,  1'b1, 1'b1, 32'd1, 32'd4, 32'd1};
    tab[4] = '{1'b1, 32'd6,   32'd3,  1'b1, 1'b1, 32'd2, 32'd5, 32'd1};
    tab[5] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b1, 32'd3, 32'd6, 32'd1};
    tab[6] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 32'd0, 32'd0, 32'd0};
    tab[7] = '{1'b1, 32'd1,   32'd55, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0};
    tab[8] = '{1'b1, 32'd512, 32'd66, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0};
    tab[9] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 32'd0, 32'd0, 32'd0};

    rst_n = 1'b0; st_en = 1'b0; st_addr = '0; st_data = '0;
    clear = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_count",    32'(count),     32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    chk("rst_fib_err",  32'(fib_err),   32'd0);
    chk("rst_data",     32'(out_data),  32'd0);
    chk("rst_addr",     32'(out_addr),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Program stores and out-of-window stores
    for (int i = 0; i < 10; i++)
      cyc_x(tab[i].en, tab[i].a, tab[i].d, tab[i].rdy, 1'b0, 1'b1,
            tab[i].ev, tab[i].ed, tab[i].ea, tab[i].ec);
    chk("prog_overflow", 32'(overflow), 32'd0);
    chk("prog_fib_err",  32'(fib_err),  32'd0);

    // Fill past full, then drain
    for (int i = 0; i < 9; i++) cyc(1'b1, 32'(10 + i), 32'(100 + i), 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("fill_count",    32'(count),    32'd8);
    chk("fill_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("drain_count", 32'(count), 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(100 + i), 32'(200 + i), 1'b0, 1'b0);
    cyc(1'b1, 32'd108, 32'd208, 1'b1, 1'b0);
    chk("fullpp_count",    32'(count),    32'd8);
    chk("fullpp_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("fullpp_last_data", 32'(out_data), 32'd208);
    chk("fullpp_last_addr", 32'(out_addr), 32'd108);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Stall hold then clear with a same-cycle push
    cyc(1'b1, 32'd30, 32'd300, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("stall_hold", 32'(out_data), 32'd300);
    end
    cyc(1'b1, 32'd31, 32'd301, 1'b0, 1'b1);
    chk("clear_count",    32'(count),     32'd0);
    chk("clear_valid",    32'(out_valid), 32'd0);
    chk("clear_overflow", 32'(overflow),  32'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(50 + i), 32'(400 + i), 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    st_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid",    32'(out_valid), 32'd0);
    chk("mrst_count",    32'(count),     32'd0);
    chk("mrst_data",     32'(out_data),  32'd0);
    chk("mrst_addr",     32'(out_addr),  32'd0);
    chk("mrst_overflow", 32'(overflow),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fibonacci checker: 0,1,1,2,4
    cyc(1'b1, 32'd40, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'd41, 32'd1, 1'b1, 1'b0);
    cyc(1'b1, 32'd42, 32'd1, 1'b1, 1'b0);
    cyc(1'b1, 32'd43, 32'd2, 1'b1, 1'b0);
    chk("fib_before_bad", 32'(fib_err), 32'd0);
    cyc(1'b1, 32'd44, 32'd4, 1'b1, 1'b0);
    chk("fib_after_bad", 32'(fib_err), 32'(fib_on()));
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("fib_sticky", 32'(fib_err), 32'(fib_on()));
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("fib_cleared", 32'(fib_err), 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
